// File: rtl/noise_voice_scheduler.sv
// noise_voice_scheduler: VOICES noise voices sharing one 23-bit LFSR step datapath.
// Accumulator tap crossings queue step requests; a round-robin arbiter serves one per clock.
module noise_voice_scheduler #(
    parameter int VOICES    = 4,
    parameter int ACC_WIDTH = 24,
    parameter int TAP_BIT   = 19
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_tick,
    input  logic                       freq_wr,
    input  logic [$clog2(VOICES)-1:0]  freq_sel,
    input  logic [15:0]                freq_data,
    input  logic [VOICES-1:0]          reseed,
    output logic [VOICES*12-1:0]       dout,
    output logic                       busy,
    output logic [VOICES-1:0]          overrun
);

    localparam int          PW   = $clog2(VOICES);
    localparam logic [22:0] SEED = 23'b01101110010010000101011;

    logic [ACC_WIDTH-1:0] acc     [VOICES];
    logic [ACC_WIDTH-1:0] acc_nxt [VOICES];
    logic [15:0]          freq    [VOICES];
    logic [22:0]          lfsr    [VOICES];
    logic [VOICES-1:0]    pending;
    logic [PW-1:0]        ptr;

    logic [VOICES-1:0]    edge_hit;
    logic [VOICES-1:0]    gnt;
    logic [PW-1:0]        gnt_idx;
    logic                 gnt_vld;
    logic [PW-1:0]        scan;

    // Next accumulator values and 0->1 crossings of the tap bit.
    always_comb begin
        edge_hit = '0;
        for (int v = 0; v < VOICES; v++) begin
            acc_nxt[v]  = acc[v] + ACC_WIDTH'(freq[v]);
            edge_hit[v] = sample_tick & ~acc[v][TAP_BIT] & acc_nxt[v][TAP_BIT];
        end
    end

    // Round-robin pick: first pending voice at or after ptr, wrapping.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int i = 0; i < VOICES; i++) begin
            scan = PW'((int'(ptr) + i) % VOICES);
            if (!gnt_vld && pending[scan]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan;
            end
        end
        gnt = gnt_vld ? (VOICES'(1) << gnt_idx) : '0;
    end

    // Accumulators and frequency registers; a write racing a tick lands after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VOICES; v++) begin
                acc[v]  <= '0;
                freq[v] <= '0;
            end
        end else begin
            for (int v = 0; v < VOICES; v++) begin
                if (sample_tick)
                    acc[v] <= acc_nxt[v];
                if (freq_wr && int'(freq_sel) == v)
                    freq[v] <= freq_data;
            end
        end
    end

    // Per-voice LFSR state, request and lost-step flags; reseed beats grant and edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < VOICES; v++)
                lfsr[v] <= SEED;
            pending <= '0;
            overrun <= '0;
        end else begin
            for (int v = 0; v < VOICES; v++) begin
                if (reseed[v]) begin
                    lfsr[v]    <= SEED;
                    pending[v] <= 1'b0;
                    overrun[v] <= 1'b0;
                end else begin
                    if (gnt[v])
                        lfsr[v] <= {lfsr[v][21:0], lfsr[v][22] ^ lfsr[v][17]};
                    if (edge_hit[v]) begin
                        pending[v] <= 1'b1;
                        if (pending[v] && !gnt[v])
                            overrun[v] <= 1'b1;
                    end else if (gnt[v]) begin
                        pending[v] <= 1'b0;
                    end
                end
            end
        end
    end

    // Pointer moves past the served voice; a reseeded grant does not count as served.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (gnt_vld && !reseed[gnt_idx])
            ptr <= (gnt_idx == PW'(VOICES - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // Noise output taps straight from the stored LFSR state.
    always_comb begin
        dout = '0;
        for (int v = 0; v < VOICES; v++)
            dout[12*v +: 12] = {lfsr[v][22], lfsr[v][20], lfsr[v][16], lfsr[v][13],
                                lfsr[v][11], lfsr[v][7],  lfsr[v][4],  lfsr[v][2],
                                4'b0000};
    end

    assign busy = |pending;

endmodule

// File: tb/tb_noise_voice_scheduler.sv
// tb_noise_voice_scheduler: directed checks of the noise voice scheduler.
// A second instance with a low tap bit makes lost steps reachable.
module tb_noise_voice_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sample_tick = 1'b0;
    logic        freq_wr = 1'b0;
    logic [1:0]  freq_sel = '0;
    logic [15:0] freq_data = '0;
    logic [3:0]  reseed = '0;
    logic [47:0] dout, dout2;
    logic        busy, busy2;
    logic [3:0]  overrun, overrun2;

    int n_cmp = 0;
    int n_err = 0;

    noise_voice_scheduler #(.VOICES(4), .ACC_WIDTH(24), .TAP_BIT(19)) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick),
        .freq_wr(freq_wr), .freq_sel(freq_sel), .freq_data(freq_data),
        .reseed(reseed), .dout(dout), .busy(busy), .overrun(overrun)
    );

    noise_voice_scheduler #(.VOICES(4), .ACC_WIDTH(24), .TAP_BIT(16)) dut2 (
        .clk(clk), .rst(rst), .sample_tick(sample_tick),
        .freq_wr(freq_wr), .freq_sel(freq_sel), .freq_data(freq_data),
        .reseed(reseed), .dout(dout2), .busy(busy2), .overrun(overrun2)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] lane(input logic [47:0] d, input int v);
        lane = d[12*v +: 12];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [15:0] data);
        freq_wr   = 1'b1;
        freq_sel  = sel;
        freq_data = data;
        step();
        freq_wr = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            sample_tick = 1'b1;
            step();
        end
        sample_tick = 1'b0;
    endtask

    initial begin
        // reset state
        do_reset();
        for (int v = 0; v < 4; v++) begin
            chk($sformatf("rst_lane%0d", v), lane(dout, v), 12'h700);
            chk($sformatf("rst2_lane%0d", v), lane(dout2, v), 12'h700);
        end
        chk("rst_busy", busy, 1'b0);
        chk("rst_overrun", overrun, 4'b0000);

        // single voice, spaced ticks
        wr(2'd0, 16'h8000);
        for (int t = 0; t < 15; t++) begin
            ticks(1);
            repeat (4) step();
        end
        chk("sv_busy_before", busy, 1'b0);
        ticks(1);
        chk("sv_busy_pend", busy, 1'b1);
        chk("sv_lane0_pend", lane(dout, 0), 12'h700);
        step();
        chk("sv_busy_after", busy, 1'b0);
        chk("sv_lane0", lane(dout, 0), 12'h8B0);
        for (int v = 1; v < 4; v++)
            chk($sformatf("sv_lane%0d", v), lane(dout, v), 12'h700);

        // all voices contend, served 0,1,2,3
        do_reset();
        for (int v = 0; v < 4; v++)
            wr(2'(v), 16'h8000);
        ticks(16);
        chk("ct_busy_pend", busy, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step();
            for (int v = 0; v < 4; v++)
                chk($sformatf("ct_g%0d_lane%0d", k, v), lane(dout, v),
                    (v <= k) ? 12'h8B0 : 12'h700);
            chk($sformatf("ct_g%0d_busy", k), busy, (k < 3) ? 1'b1 : 1'b0);
        end
        chk("ct_overrun", overrun, 4'b0000);

        // fairness: ptr at 2, voices 0 and 3 pending -> 3 first
        do_reset();
        wr(2'd1, 16'h8000);
        ticks(16);
        step();
        chk("rr_setup_lane1", lane(dout, 1), 12'h8B0);
        wr(2'd1, 16'h0000);
        wr(2'd0, 16'h8000);
        wr(2'd3, 16'h8000);
        ticks(16);
        chk("rr_busy_pend", busy, 1'b1);
        step();
        chk("rr_first_lane3", lane(dout, 3), 12'h8B0);
        chk("rr_first_lane0", lane(dout, 0), 12'h700);
        step();
        chk("rr_second_lane0", lane(dout, 0), 12'h8B0);
        chk("rr_busy_done", busy, 1'b0);

        // overrun on voice 1 while 2 and 3 are served ahead of it
        do_reset();
        wr(2'd1, 16'hFFFF);
        ticks(2);
        step();
        chk("ov_setup_lane1", lane(dout2, 1), 12'h8B0);
        chk("ov_setup_busy", busy2, 1'b0);
        wr(2'd2, 16'hFFFF);
        wr(2'd3, 16'hFFFF);
        ticks(4);
        chk("ov_flag", overrun2, 4'b0010);
        chk("ov_busy", busy2, 1'b1);
        repeat (4) step();
        chk("ov_sticky", overrun2, 4'b0010);
        chk("ov_busy_drained", busy2, 1'b0);
        reseed = 4'b0010;
        step();
        reseed = 4'b0000;
        chk("ov_reseed_flag", overrun2, 4'b0000);
        chk("ov_reseed_lane1", lane(dout2, 1), 12'h700);

        // frequency write in the same cycle as a tick uses the old value
        do_reset();
        wr(2'd0, 16'h8000);
        ticks(15);
        freq_wr     = 1'b1;
        freq_sel    = 2'd0;
        freq_data   = 16'h0000;
        sample_tick = 1'b1;
        step();
        freq_wr     = 1'b0;
        sample_tick = 1'b0;
        chk("fw_busy", busy, 1'b1);
        step();
        chk("fw_lane0", lane(dout, 0), 12'h8B0);

        // reseed racing a grant: no step, pointer stays at 0
        do_reset();
        wr(2'd0, 16'h8000);
        ticks(16);
        chk("rs_busy_pend", busy, 1'b1);
        reseed = 4'b0001;
        step();
        reseed = 4'b0000;
        chk("rs_lane0", lane(dout, 0), 12'h700);
        chk("rs_busy", busy, 1'b0);
        ticks(16);
        chk("rs_no_edge", busy, 1'b0);
        wr(2'd3, 16'h8000);
        ticks(16);
        chk("rs_busy_both", busy, 1'b1);
        step();
        chk("rs_first_lane0", lane(dout, 0), 12'h8B0);
        chk("rs_first_lane3", lane(dout, 3), 12'h700);
        step();
        chk("rs_second_lane3", lane(dout, 3), 12'h8B0);
        chk("rs_busy_done", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/noise_voice_scheduler.md
# noise_voice_scheduler

Time-multiplexed controller that shares one 23-bit SID-style noise LFSR step datapath among VOICES independent noise voices. Each voice has its own frequency register, phase accumulator and stored LFSR state. Accumulator bit crossings raise step requests, and a round-robin arbiter grants one LFSR step per clock. The block sits between the voice register interface and the waveform mixer, and supplies 12-bit noise per voice.

## Interface
- VOICES, 4, number of noise voices (2..8)
- ACC_WIDTH, 24, phase accumulator width
- TAP_BIT, 19, accumulator bit whose 0->1 transition requests an LFSR step (< ACC_WIDTH)
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- sample_tick  input  1  one-cycle strobe; all accumulators advance
- freq_wr  input  1  write strobe for a frequency register
- freq_sel  input  $clog2(VOICES)  voice index for freq_wr
- freq_data  input  16  frequency value; zero-extended to ACC_WIDTH
- reseed  input  VOICES  per-voice reseed strobe
- dout  output  VOICES*12  voice v noise at [12v+11:12v]
- busy  output  1  high while any request is pending
- overrun  output  VOICES  sticky per-voice lost-step flag

## Operation
- Seed: 23'b01101110010010000101011. Step: lfsr <= {lfsr[21:0], lfsr[22]^lfsr[17]}.
- dout per voice: {l[22],l[20],l[16],l[13],l[11],l[7],l[4],l[2],4'b0000}. Registered. Driven directly from the stored state.
- freq_wr: freq[freq_sel] <= freq_data. A write in the same cycle as sample_tick does not affect that tick; the old value is used.
- sample_tick: acc[v] <= acc[v] + freq[v], modulo 2^ACC_WIDTH. Wrap is silent.
- Edge detect: old acc[v][TAP_BIT]==0 and new ==1 is an edge. An edge sets pending[v].
- Edge while pending[v] is already set and not granted this cycle: pending stays 1 and overrun[v] <= 1. The extra step is lost.
- Edge in the same cycle that voice v is granted: pending[v] stays 1 for the new request. No overrun.
- Arbiter, every cycle: if pending != 0, grant the first pending index at or after ptr, searching cyclically.
  - The granted voice's LFSR steps once and its pending bit clears, unless the same-cycle edge rule above applies.
  - ptr <= (grant+1) mod VOICES.
  - With no pending request, ptr holds.
- reseed[v]:
  - lfsr[v] <= seed; pending[v] <= 0; overrun[v] <= 0.
  - Overrides a grant or edge for v in the same cycle. In that case v is not stepped and ptr does not advance.
  - acc[v] and freq[v] are unaffected.
- busy = |pending. Combinational from registers.

## Timing
- Reset, synchronous: acc=0, freq=0, pending=0, overrun=0, ptr=0, every lfsr=seed.
  - Every dout lane reads 12'h700 from the first clock after rst is sampled.
  - busy=0.
  - rst mid-operation discards all pending requests.
- Edge n: sample_tick is sampled at edge n and pending is set at n.
- Grant at edge n+1 at the earliest. New dout is visible after edge n+1, i.e. 2 edges after the tick is sampled.
- Worst-case grant latency is VOICES cycles after pending is set, when all voices contend.
- Throughput: one LFSR step per clock total. A voice loses steps only if its edges arrive faster than its round-robin slot.

## Test plan
- Reset: assert rst 2 cycles -> every dout lane = 12'h700, busy=0, overrun=0.
- Single voice: freq[0]=16'h8000, pulse sample_tick 16 times, 4 idle cycles between ticks -> after tick 16, busy high 1 cycle, dout[11:0] becomes 12'h8B0, other lanes stay 12'h700.
- Contention: all freq=16'h8000, 16 ticks -> pending=4'b1111. Grants follow on the next 4 cycles in order 0,1,2,3, busy drops after the 4th. All lanes = 12'h8B0, no overrun.
- Round-robin fairness: ptr at 2, pending voices 0 and 3 -> voice 3 granted first, then voice 0.
- Overrun: freq[1]=16'hFFFF; hold voice 2 pending; keep voice 1 contending with back-to-back ticks so its second edge arrives before its grant -> overrun[1]=1 and stays 1. reseed[1] -> overrun[1]=0, lane 1 = 12'h700.
- Simultaneous events, same cycle:
  - freq_wr with sample_tick -> that tick uses the old value.
  - reseed[0] with a grant of voice 0 -> lane 0 = 12'h700 and ptr unchanged.
